// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared definitions for the RGB fade sequencer: state encoding, colour-word
// field offsets, default tick divider and the gamma-2.2 table builder used by
// the optional output stage (RGB_FADE_GAMMA_EN).
package rgb_fade_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FADE = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Bit offsets of each channel inside the 24-bit colour word.
   localparam int RED_LSB   = 16;
   localparam int GREEN_LSB = 8;
   localparam int BLUE_LSB  = 0;

   // 1 ms fade tick at a 100 MHz GCLK.
   localparam logic [19:0] DEFAULT_TICK_DIV = 20'd100000;

   typedef logic [255:0][7:0] gamma_lut_t;

   // One fade step of a single channel toward its target. The sum and the
   // difference are formed in 9 bits so a large step clamps at the target
   // instead of wrapping around 0 or 255.
   function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                              input logic [7:0] tgt,
                                              input logic [7:0] step);
      logic [8:0] up;
      logic [8:0] dn;
      logic [7:0] res;
      up  = {1'b0, cur} + {1'b0, step};
      dn  = {1'b0, cur} - {1'b0, step};
      res = cur;
      if (cur < tgt) begin
         res = (up > {1'b0, tgt}) ? tgt : up[7:0];
      end else if (cur > tgt) begin
         res = (dn[8] || (dn < {1'b0, tgt})) ? tgt : dn[7:0];
      end
      return res;
   endfunction

   // round(255 * (x/255)^2.2) using integer arithmetic only.
   // y is the largest value with y - 0.5 <= exact result, which rearranges to
   // (2y-1)^5 * 255^6 <= 32 * x^11; a binary search over y finds it.
   function automatic logic [7:0] gamma22(input logic [7:0] x);
      logic [127:0] x11;
      logic [127:0] k6;
      logic [127:0] odd;
      logic [127:0] odd5;
      logic [7:0]   y;
      logic [7:0]   cand;
      x11 = 128'd32;
      for (int i = 0; i < 11; i++) x11 = x11 * 128'(x);
      k6 = 128'd1;
      for (int i = 0; i < 6; i++) k6 = k6 * 128'd255;
      y = 8'd0;
      for (int b = 7; b >= 0; b--) begin
         cand = y | (8'd1 << b);
         odd  = (128'(cand) << 1) - 128'd1;
         odd5 = odd * odd * odd * odd * odd * k6;
         if (odd5 <= x11) y = cand;
      end
      return y;
   endfunction

   function automatic gamma_lut_t build_gamma_lut();
      gamma_lut_t t;
      for (int i = 0; i < 256; i++) t[i] = gamma22(8'(i));
      return t;
   endfunction

endpackage

// File: rtl/rgb_fade_sequencer_gamma_lut.sv
// rgb_gamma_lut: 8-to-8 registered gamma-2.2 ROM for one colour channel.
// Only instantiated when RGB_FADE_GAMMA_EN is defined.
module rgb_gamma_lut
   import rgb_fade_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam gamma_lut_t LUT = build_gamma_lut();

   // Registered table lookup; adds one cycle of latency.
   // NOTE: the table itself is a constant and needs no reset; only the output
   // register is reset so the channel reads 0 right after reset.
   always_ff @(posedge clk) begin
      if (rst) dout <= '0;
      else     dout <= LUT[din];
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: accepts a target colour + hold time, ramps the R/G/B
// intensities toward it one STEP per fade tick, holds, then pulses DONE_O.
// Optional macro RGB_FADE_GAMMA_EN inserts a registered gamma-2.2 ROM on the
// outputs (one extra cycle of latency, DONE_O delayed to match).
module rgb_fade_sequencer
   import rgb_fade_sequencer_pkg::*;
#(
   parameter logic [19:0] TICK_DIV = DEFAULT_TICK_DIV,
   parameter logic [7:0]  STEP     = 8'd1
)
(
   input  logic        GCLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [23:0] CMD_RGB,
   input  logic [7:0]  CMD_HOLD,
   output logic [7:0]  RED_O,
   output logic [7:0]  GREEN_O,
   output logic [7:0]  BLUE_O,
   output logic        BUSY_O,
   output logic        DONE_O
);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  cur_r, cur_g, cur_b;
   logic [7:0]  tgt_r, tgt_g, tgt_b;
   logic [7:0]  hold_len;
   logic [7:0]  hold_cnt;
   logic [19:0] tick_cnt;
   logic        tick;
   logic        at_target;
   logic        done_q;

   assign tick      = (state != IDLE) && (tick_cnt == TICK_DIV - 20'd1);
   assign at_target = (cur_r == tgt_r) && (cur_g == tgt_g) && (cur_b == tgt_b);

   // State register.
   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge GCLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; target equality is checked every cycle, not only on tick.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (CMD_VALID)           state_nxt = FADE;
         FADE: if (at_target)           state_nxt = (hold_len == 8'd0) ? IDLE : HOLD;
         HOLD: if (hold_cnt == 8'd0)    state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      CMD_READY = (state == IDLE);
      BUSY_O    = (state == FADE) || (state == HOLD);
   end

   // Datapath: command latch, tick counter, colour ramp and hold countdown.
   always_ff @(posedge GCLK) begin
      if (RST) begin
         cur_r    <= '0;
         cur_g    <= '0;
         cur_b    <= '0;
         tgt_r    <= '0;
         tgt_g    <= '0;
         tgt_b    <= '0;
         hold_len <= '0;
         hold_cnt <= '0;
         tick_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (CMD_VALID) begin
                  tgt_r    <= CMD_RGB[RED_LSB   +: 8];
                  tgt_g    <= CMD_RGB[GREEN_LSB +: 8];
                  tgt_b    <= CMD_RGB[BLUE_LSB  +: 8];
                  hold_len <= CMD_HOLD;
                  tick_cnt <= '0;
               end
            end
            FADE: begin
               if (at_target) begin
                  hold_cnt <= hold_len;
                  tick_cnt <= '0;
               end else begin
                  tick_cnt <= tick ? 20'd0 : tick_cnt + 20'd1;
                  if (tick) begin
                     cur_r <= step_toward(cur_r, tgt_r, STEP);
                     cur_g <= step_toward(cur_g, tgt_g, STEP);
                     cur_b <= step_toward(cur_b, tgt_b, STEP);
                  end
               end
            end
            HOLD: begin
               tick_cnt <= tick ? 20'd0 : tick_cnt + 20'd1;
               if (tick && (hold_cnt != 8'd0)) hold_cnt <= hold_cnt - 8'd1;
            end
            default: tick_cnt <= '0;
         endcase
      end
   end

   // Completion pulse: set for the first IDLE cycle after FADE/HOLD.
   always_ff @(posedge GCLK) begin
      if (RST) done_q <= 1'b0;
      else     done_q <= (state != IDLE) && (state_nxt == IDLE);
   end

`ifdef RGB_FADE_GAMMA_EN
   logic done_d;

   rgb_gamma_lut u_lut_r (.clk(GCLK), .rst(RST), .din(cur_r), .dout(RED_O));
   rgb_gamma_lut u_lut_g (.clk(GCLK), .rst(RST), .din(cur_g), .dout(GREEN_O));
   rgb_gamma_lut u_lut_b (.clk(GCLK), .rst(RST), .din(cur_b), .dout(BLUE_O));

   // Delay DONE_O by the ROM latency so it lines up with the final colour.
   always_ff @(posedge GCLK) begin
      if (RST) done_d <= 1'b0;
      else     done_d <= done_q;
   end

   assign DONE_O = done_d;
`else
   assign RED_O   = cur_r;
   assign GREEN_O = cur_g;
   assign BLUE_O  = cur_b;
   assign DONE_O  = done_q;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Testbench for rgb_fade_sequencer: three instances (STEP = 1, 2, 200) with
// TICK_DIV = 4. Table-driven commands checked through a scoreboard, plus
// cycle-by-cycle sequences for ramp, mixed direction, clamping, backpressure
// and reset mid-fade. Expectations adapt when RGB_FADE_GAMMA_EN is defined.
module tb_rgb_fade_sequencer;

   localparam logic [7:0] STEPS [3] = '{8'd1, 8'd2, 8'd200};
`ifdef RGB_FADE_GAMMA_EN
   localparam int GL = 1;
`else
   localparam int GL = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       cmd_valid = '0;
   logic [2:0]       cmd_ready;
   logic [2:0][23:0] cmd_rgb = '0;
   logic [2:0][7:0]  cmd_hold = '0;
   logic [2:0][7:0]  red, green, blue;
   logic [2:0]       busy, done;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      rgb_fade_sequencer #(.TICK_DIV(20'd4), .STEP(STEPS[gi])) u_dut (
         .GCLK(clk), .RST(rst),
         .CMD_VALID(cmd_valid[gi]), .CMD_READY(cmd_ready[gi]),
         .CMD_RGB(cmd_rgb[gi]), .CMD_HOLD(cmd_hold[gi]),
         .RED_O(red[gi]), .GREEN_O(green[gi]), .BLUE_O(blue[gi]),
         .BUSY_O(busy[gi]), .DONE_O(done[gi])
      );
   end

   typedef struct {
      int          id;
      logic [23:0] rgb;
      logic [7:0]  hold;
      logic [23:0] exp_rgb;
      int          lat;
   } vec_t;

   typedef struct {
      int          id;
      logic [23:0] rgb;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] g8(input logic [7:0] v);
`ifdef RGB_FADE_GAMMA_EN
      real r;
      r = 255.0 * ((real'(v) / 255.0) ** 2.2);
      return 8'($rtoi(r + 0.5));
`else
      return v;
`endif
   endfunction

   function automatic logic [23:0] xf(input logic [23:0] c);
      return {g8(c[23:16]), g8(c[15:8]), g8(c[7:0])};
   endfunction

   function automatic logic [23:0] rgb_of(input int id);
      return {red[id], green[id], blue[id]};
   endfunction

   // Drive one command at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input int id, input logic [23:0] rgb, input logic [7:0] hold,
                        input logic [23:0] exp_rgb, input int lat);
      exp_t e;
      check("ready_before_cmd", cmd_ready[id], 1);
      cmd_valid[id] = 1'b1;
      cmd_rgb[id]   = rgb;
      cmd_hold[id]  = hold;
      e.id = id; e.rgb = xf(exp_rgb); e.lat = lat + GL; e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      cmd_valid[id] = 1'b0;
   endtask

   task automatic wait_done();
      exp_t e;
      int   n;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty");
         return;
      end
      e = sb.pop_front();
      n = 0;
      while (!done[e.id] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done[e.id]) begin
         total++; bad++;
         $display("FAIL done_timeout: dut %0d no DONE_O within 300 cycles", e.id);
      end else begin
         check("done_latency", 32'(cyc - e.acc), 32'(e.lat));
         check("done_colour", rgb_of(e.id), e.rgb);
      end
   endtask

   // Cycle-by-cycle view of a hold-0 command; c0..c3 are the colours before
   // and after each tick.
   task automatic track(input int id, input logic [23:0] rgb,
                        input logic [23:0] c0, input logic [23:0] c1,
                        input logic [23:0] c2, input logic [23:0] c3,
                        input int nticks, input string tag);
      int          last;
      int          j;
      logic [23:0] exp;
      cmd_valid[id] = 1'b1;
      cmd_rgb[id]   = rgb;
      cmd_hold[id]  = 8'd0;
      @(negedge clk);
      cmd_valid[id] = 1'b0;
      last = 4 * nticks + 2 + GL;
      for (int k = 0; k <= last; k++) begin
         j = (k < GL) ? 0 : (k - GL) / 4;
         if (j > nticks) j = nticks;
         exp = (j == 0) ? c0 : (j == 1) ? c1 : (j == 2) ? c2 : c3;
         check({tag, "_rgb"},   rgb_of(id), xf(exp));
         check({tag, "_done"},  done[id], (k == 4 * nticks + 1 + GL) ? 1 : 0);
         check({tag, "_busy"},  busy[id], (k < 4 * nticks + 1) ? 1 : 0);
         check({tag, "_ready"}, cmd_ready[id], (k < 4 * nticks + 1) ? 0 : 1);
         if (k < last) @(negedge clk);
      end
   endtask

   initial begin
      vec_t vecs [6];
      int   acc;
      int   n;

      vecs[0] = '{0, 24'h030000, 8'd0, 24'h030000, 1};
      vecs[1] = '{0, 24'h010202, 8'd0, 24'h010202, 9};
      vecs[2] = '{0, 24'h010202, 8'd1, 24'h010202, 6};
      vecs[3] = '{0, 24'h000001, 8'd2, 24'h000001, 18};
      vecs[4] = '{1, 24'h030000, 8'd0, 24'h030000, 9};
      vecs[5] = '{2, 24'h64FA00, 8'd0, 24'h64FA00, 9};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_rgb",   rgb_of(i), 0);
         check("rst_ready", cmd_ready[i], 1);
         check("rst_busy",  busy[i], 0);
         check("rst_done",  done[i], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Ramp up on STEP=1: red 1,2,3 on successive ticks.
      track(0, 24'h030000, 24'h000000, 24'h010000, 24'h020000, 24'h030000, 3, "ramp");

      // Table-driven commands through the scoreboard.
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].id, vecs[i].rgb, vecs[i].hold, vecs[i].exp_rgb, vecs[i].lat);
         wait_done();
      end

      // Mixed direction on STEP=2 from (3,0,0).
      track(1, 24'h000205, 24'h030000, 24'h010202, 24'h000204, 24'h000205, 3, "mixed");

      // Clamping on STEP=200 from (100,250,0): no wrap past 255 or 0.
      track(2, 24'hFF0000, 24'h64FA00, 24'hFF3200, 24'hFF0000, 24'hFF0000, 2, "clamp");

      // (128,255,0) from (255,0,0); with the gamma ROM the red channel reads 56.
      issue(2, 24'h80FF00, 8'd0, 24'h80FF00, 9);
      wait_done();
`ifdef RGB_FADE_GAMMA_EN
      check("gamma_128", red[2], 8'd56);
`endif

      // Hold 2 with CMD_VALID held high: second command waits for READY.
      cmd_valid[0] = 1'b1;
      cmd_rgb[0]   = 24'h020000;
      cmd_hold[0]  = 8'd2;
      acc = cyc + 1;
      @(negedge clk);
      cmd_rgb[0]  = 24'h020000;
      cmd_hold[0] = 8'd0;
      n = 0;
      while (!cmd_ready[0] && n < 100) begin
         check("bp_no_done_while_busy", done[0], 0);
         @(negedge clk);
         n++;
      end
      check("bp_ready_latency", 32'(cyc - acc), 32'd18);
      check("bp_done_with_ready", done[0], (GL == 0) ? 1 : 0);
      check("bp_hold_colour", rgb_of(0), xf(24'h020000));
      begin
         exp_t e;
         e.id = 0; e.rgb = xf(24'h020000); e.lat = 1 + GL; e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      check("bp_second_accepted", busy[0], 1);
      check("bp_delayed_done", done[0], (GL == 1) ? 1 : 0);
      @(negedge clk);
      wait_done();

      // Reset mid-fade aborts the command.
      cmd_valid[0] = 1'b1;
      cmd_rgb[0]   = 24'hC8C8C8;
      cmd_hold[0]  = 8'd0;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      repeat (9) @(negedge clk);
      check("midfade_rgb", rgb_of(0), xf(24'h040202));
      check("midfade_busy", busy[0], 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rgb",   rgb_of(0), 0);
      check("abort_ready", cmd_ready[0], 1);
      check("abort_busy",  busy[0], 0);
      check("abort_done",  done[0], 0);
      rst = 1'b0;
      @(negedge clk);
      issue(0, 24'h010000, 8'd0, 24'h010000, 5);
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
